// File: rtl/aes32_dec_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes32_dec_round_ctrl
//  Description : Round sequencer for the 32-bit, pipelined AES decryption
//                datapath. Issues the four column words of every round into
//                the datapath, selects ciphertext or feedback as the datapath
//                input, steps the round-key address in decryption order,
//                flags the final round and marks the four plaintext words as
//                they leave the pipeline. Holds no data itself.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NR        number of decryption rounds (10, 12 or 14)
//    PIPE_LAT  datapath latency from injection to feedback input (4..16)
//  Ports
//    CLK        in   clock, rising edge
//    RST_N      in   asynchronous reset, active low
//    START      in   one-cycle request to decrypt a block (honoured in idle)
//    IN_RDY     out  datapath takes a ciphertext word this cycle
//    SEL_FB     out  datapath input select: 0 ciphertext, 1 feedback
//    CTRL       out  column control of the feedback network (word index)
//    WORD_VLD   out  a word enters the datapath this cycle
//    RKEY_ADDR  out  round-key word address
//    LAST_RND   out  current round is the final one (no InvMixColumns)
//    OUT_VLD    out  plaintext word present at the datapath output
//    BUSY       out  block in progress
//    DONE       out  pulse with the last plaintext word
// ============================================================================
module aes32_dec_round_ctrl #(
    parameter int NR       = 10,
    parameter int PIPE_LAT = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    output logic       IN_RDY,
    output logic       SEL_FB,
    output logic [1:0] CTRL,
    output logic       WORD_VLD,
    output logic [5:0] RKEY_ADDR,
    output logic       LAST_RND,
    output logic       OUT_VLD,
    output logic       BUSY,
    output logic       DONE
);

    // Counter widths are sized for the largest legal parameters
    // (PIPE_LAT up to 16, NR up to 14) so every compare is full width.
    localparam int              c_PH_W       = 5;
    localparam int              c_RND_W      = 4;
    localparam logic [c_PH_W-1:0]  c_LAST_PH  = c_PH_W'(PIPE_LAT - 1);
    localparam logic [c_RND_W-1:0] c_LAST_RND = c_RND_W'(NR);
    localparam logic [c_PH_W-1:0]  c_WORDS    = c_PH_W'(4);
    localparam logic [c_PH_W-1:0]  c_DRAIN_END = c_PH_W'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_nxt_state;
    logic [c_PH_W-1:0]    r_phase;
    logic [c_PH_W-1:0]    w_nxt_phase;
    logic [c_RND_W-1:0]   r_round;
    logic [c_RND_W-1:0]   w_nxt_round;

    // Next-cycle output values; registered below so every output is a flop.
    logic                 w_in_rdy;
    logic                 w_sel_fb;
    logic [1:0]           w_ctrl;
    logic                 w_word_vld;
    logic [5:0]           w_rkey_addr;
    logic                 w_last_rnd;
    logic                 w_out_vld;
    logic                 w_busy;
    logic                 w_done;

    logic                 w_issue;
    logic [c_RND_W-1:0]   w_rnd_left;

    // ------------------------------------------------------------------------
    // State and counter register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_round <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_phase <= w_nxt_phase;
            r_round <= w_nxt_round;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic and next-cycle outputs.
    // Outputs are derived from the *next* state so that, once registered,
    // they line up with the state they describe: the cycle after START
    // already carries the first word of round 0.
    // ------------------------------------------------------------------------
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_phase = r_phase;
        w_nxt_round = r_round;

        unique case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_nxt_state = S_RUN;
                    w_nxt_phase = '0;
                    w_nxt_round = '0;
                end
            end
            S_RUN: begin
                if (r_phase == c_LAST_PH) begin
                    w_nxt_phase = '0;
                    if (r_round == c_LAST_RND) begin
                        w_nxt_state = S_DRAIN;
                        w_nxt_round = '0;
                    end else begin
                        w_nxt_round = r_round + 1'b1;
                    end
                end else begin
                    w_nxt_phase = r_phase + 1'b1;
                end
            end
            S_DRAIN: begin
                // The four result words of the final round emerge in the
                // first four phases after the last injection period.
                if (r_phase == c_DRAIN_END) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_phase = '0;
                end else begin
                    w_nxt_phase = r_phase + 1'b1;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
                w_nxt_phase = '0;
                w_nxt_round = '0;
            end
        endcase

        // Words are injected only in the first four phases of a period; the
        // remaining phases wait for the pipeline to bring the column back.
        w_issue    = (w_nxt_state == S_RUN) && (w_nxt_phase < c_WORDS);
        w_rnd_left = c_LAST_RND - w_nxt_round;

        w_word_vld  = w_issue;
        w_in_rdy    = w_issue && (w_nxt_round == '0);
        w_sel_fb    = (w_nxt_state == S_RUN) && (w_nxt_round != '0);
        w_ctrl      = w_issue ? w_nxt_phase[1:0] : 2'd0;
        w_last_rnd  = (w_nxt_state == S_RUN) && (w_nxt_round == c_LAST_RND);
        w_out_vld   = (w_nxt_state == S_DRAIN);
        w_done      = (w_nxt_state == S_DRAIN) && (w_nxt_phase == c_DRAIN_END);
        w_busy      = (w_nxt_state != S_IDLE);

        // Key words are consumed last-round-first: (NR-round)*4 + word.
        // Since word < 4 this is a plain concatenation. Between issues the
        // address holds; it returns to zero only when the block is over.
        if (w_issue) begin
            w_rkey_addr = {w_rnd_left, w_nxt_phase[1:0]};
        end else if (w_nxt_state == S_IDLE) begin
            w_rkey_addr = 6'd0;
        end else begin
            w_rkey_addr = RKEY_ADDR;
        end
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            IN_RDY    <= 1'b0;
            SEL_FB    <= 1'b0;
            CTRL      <= 2'd0;
            WORD_VLD  <= 1'b0;
            RKEY_ADDR <= 6'd0;
            LAST_RND  <= 1'b0;
            OUT_VLD   <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            IN_RDY    <= w_in_rdy;
            SEL_FB    <= w_sel_fb;
            CTRL      <= w_ctrl;
            WORD_VLD  <= w_word_vld;
            RKEY_ADDR <= w_rkey_addr;
            LAST_RND  <= w_last_rnd;
            OUT_VLD   <= w_out_vld;
            BUSY      <= w_busy;
            DONE      <= w_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes32_dec_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes32_dec_round_ctrl
//  Description : Bench for aes32_dec_round_ctrl. Two instances (NR=10 with
//                PIPE_LAT=8, NR=14 with PIPE_LAT=4) are driven side by side
//                and compared every cycle against a timeline model: each
//                instance's behaviour is a function of the number of cycles
//                since its last accepted START.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes32_dec_round_ctrl;

    localparam int c_NR0 = 10;
    localparam int c_PL0 = 8;
    localparam int c_NR1 = 14;
    localparam int c_PL1 = 4;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [1:0] start;
    logic [1:0] in_rdy, sel_fb, word_vld, last_rnd, out_vld, busy, done;
    logic [1:0] ctrl [2];
    logic [5:0] rkey [2];

    always #5 CLK = ~CLK;

    aes32_dec_round_ctrl #(.NR(c_NR0), .PIPE_LAT(c_PL0)) u_dut0 (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (start[0]),
        .IN_RDY    (in_rdy[0]),
        .SEL_FB    (sel_fb[0]),
        .CTRL      (ctrl[0]),
        .WORD_VLD  (word_vld[0]),
        .RKEY_ADDR (rkey[0]),
        .LAST_RND  (last_rnd[0]),
        .OUT_VLD   (out_vld[0]),
        .BUSY      (busy[0]),
        .DONE      (done[0])
    );

    aes32_dec_round_ctrl #(.NR(c_NR1), .PIPE_LAT(c_PL1)) u_dut1 (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (start[1]),
        .IN_RDY    (in_rdy[1]),
        .SEL_FB    (sel_fb[1]),
        .CTRL      (ctrl[1]),
        .WORD_VLD  (word_vld[1]),
        .RKEY_ADDR (rkey[1]),
        .LAST_RND  (last_rnd[1]),
        .OUT_VLD   (out_vld[1]),
        .BUSY      (busy[1]),
        .DONE      (done[1])
    );

    int vectors     = 0;
    int miscompares = 0;
    // age = cycles since the accepted START (0 = idle, 1 = first word)
    int age       [2] = '{0, 0};
    int done_exp  [2] = '{0, 0};
    int done_seen [2] = '{0, 0};

    function automatic int nr_of(input int d);
        return (d == 0) ? c_NR0 : c_NR1;
    endfunction

    function automatic int pl_of(input int d);
        return (d == 0) ? c_PL0 : c_PL1;
    endfunction

    function automatic int end_of(input int d);
        return (nr_of(d) + 1) * pl_of(d) + 4;
    endfunction

    task automatic chk(input string tag, input int d, input logic [5:0] obs, input logic [5:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d age=%0d observed=%0d expected=%0d", tag, d, age[d], obs, exp);
        end
    endtask

    // Expected outputs from the decryption timeline for the current cycle.
    task automatic check_dut(input int d);
        int a, nr, pl, r, p, dr;
        a  = age[d];
        nr = nr_of(d);
        pl = pl_of(d);
        if (a == 0) begin
            chk("IN_RDY", d, 6'(in_rdy[d]), 6'd0);
            chk("SEL_FB", d, 6'(sel_fb[d]), 6'd0);
            chk("CTRL", d, 6'(ctrl[d]), 6'd0);
            chk("WORD_VLD", d, 6'(word_vld[d]), 6'd0);
            chk("RKEY_ADDR", d, rkey[d], 6'd0);
            chk("LAST_RND", d, 6'(last_rnd[d]), 6'd0);
            chk("OUT_VLD", d, 6'(out_vld[d]), 6'd0);
            chk("BUSY", d, 6'(busy[d]), 6'd0);
            chk("DONE", d, 6'(done[d]), 6'd0);
        end else if (a <= (nr + 1) * pl) begin
            r = (a - 1) / pl;
            p = (a - 1) % pl;
            if (p < 4) begin
                chk("WORD_VLD", d, 6'(word_vld[d]), 6'd1);
                chk("CTRL", d, 6'(ctrl[d]), 6'(p));
                chk("RKEY_ADDR", d, rkey[d], 6'((nr - r) * 4 + p));
                chk("IN_RDY", d, 6'(in_rdy[d]), (r == 0) ? 6'd1 : 6'd0);
                chk("SEL_FB", d, 6'(sel_fb[d]), (r == 0) ? 6'd0 : 6'd1);
            end else begin
                chk("WORD_VLD", d, 6'(word_vld[d]), 6'd0);
                chk("CTRL", d, 6'(ctrl[d]), 6'd0);
                chk("RKEY_ADDR", d, rkey[d], 6'((nr - r) * 4 + 3));
                chk("IN_RDY", d, 6'(in_rdy[d]), 6'd0);
                if (r != 0) chk("SEL_FB", d, 6'(sel_fb[d]), 6'd1);
            end
            chk("LAST_RND", d, 6'(last_rnd[d]), (r == nr) ? 6'd1 : 6'd0);
            chk("OUT_VLD", d, 6'(out_vld[d]), 6'd0);
            chk("BUSY", d, 6'(busy[d]), 6'd1);
            chk("DONE", d, 6'(done[d]), 6'd0);
        end else begin
            dr = a - (nr + 1) * pl - 1;
            chk("OUT_VLD", d, 6'(out_vld[d]), 6'd1);
            chk("WORD_VLD", d, 6'(word_vld[d]), 6'd0);
            chk("SEL_FB", d, 6'(sel_fb[d]), 6'd0);
            chk("LAST_RND", d, 6'(last_rnd[d]), 6'd0);
            chk("IN_RDY", d, 6'(in_rdy[d]), 6'd0);
            chk("BUSY", d, 6'(busy[d]), 6'd1);
            chk("DONE", d, 6'(done[d]), (dr == 3) ? 6'd1 : 6'd0);
            if (dr == 3) done_exp[d]++;
        end
        if (done[d] === 1'b1) done_seen[d]++;
    endtask

    // One clock cycle: check at the falling edge, present START, then let
    // the model follow the rising edge.
    task automatic cyc(input logic s0, input logic s1);
        @(negedge CLK);
        check_dut(0);
        check_dut(1);
        start = {s1, s0};
        @(posedge CLK);
        for (int d = 0; d < 2; d++) begin
            if (age[d] == 0) begin
                if (start[d]) age[d] = 1;
            end else if (age[d] == end_of(d)) begin
                age[d] = 0;
            end else begin
                age[d]++;
            end
        end
    endtask

    initial begin
        RST_N = 1'b0;
        start = 2'b00;
        repeat (3) @(posedge CLK);
        #2 RST_N = 1'b1;

        // Idle after reset
        repeat (20) cyc(1'b0, 1'b0);

        // One block each; START pulses while running and on the DONE
        // cycle of dut0 (t+92) are ignored, t+93 is accepted.
        cyc(1'b1, 1'b1);
        for (int i = 1; i <= 100; i++) begin
            cyc((i == 30) || (i == 92) || (i == 93), (i == 20) || (i == 64));
        end
        repeat (120) cyc(1'b0, 1'b0);

        // START held high: back-to-back blocks every 93 / 65 cycles
        repeat (290) cyc(1'b1, 1'b1);
        repeat (120) cyc(1'b0, 1'b0);

        // Asynchronous reset in round 5, phase 2 of dut0
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 100 && age[0] != 1 + 5 * c_PL0 + 2; i++) cyc(1'b0, 1'b0);
        chk("REACH_R5P2", 0, 6'(age[0]), 6'(1 + 5 * c_PL0 + 2));
        @(negedge CLK);
        check_dut(0);
        check_dut(1);
        #2 RST_N = 1'b0;
        #1;
        age[0] = 0;
        age[1] = 0;
        check_dut(0);
        check_dut(1);
        @(posedge CLK);
        #2 RST_N = 1'b1;
        repeat (120) cyc(1'b0, 1'b0);

        // Random START traffic
        for (int i = 0; i < 2500; i++) begin
            cyc($urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
        end
        repeat (120) cyc(1'b0, 1'b0);

        chk("DONE_COUNT", 0, 6'(done_seen[0]), 6'(done_exp[0]));
        chk("DONE_COUNT", 1, 6'(done_seen[1]), 6'(done_exp[1]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
